// File: rtl/wb_master_pkg.sv
// ============================================================================
// Module      : wb_master_pkg
// Description : Shared types and constants for the Wishbone classic master
//               controller: bus widths, FSM state type, command record layout
//               and the default transfer timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_master_pkg;

    localparam int WB_AW           = 32;
    localparam int WB_DW           = 32;
    localparam int WB_SW           = 4;
    localparam int TIMEOUT_CYC_DEF = 255;

    // Binary-encoded controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One buffered command: 1 + 4 + 32 + 32 = 69 bits
    typedef struct packed {
        logic             we;
        logic [WB_SW-1:0] sel;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/wb_cmd_fifo.sv
// ============================================================================
// Module      : wb_cmd_fifo
// Description : Two-entry command FIFO (69-bit we/sel/adr/dat records).
//               Head entry is presented combinationally on o_data. A push
//               while full is dropped even if a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_cmd_fifo
    import wb_master_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_data,
    output logic o_full,
    output logic o_empty
);

    cmd_t       r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push_ok;
    logic       w_pop_ok;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since the count gates visibility
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_master_ctrl.sv
// ============================================================================
// Module      : wb_master_ctrl
// Description : Wishbone classic single-transfer master. Commands are queued
//               in a 2-entry FIFO, issued one at a time on the bus, and each
//               produces one response (read data or zero, plus error flag).
//               Optional macro WB_MASTER_TIMEOUT_EN builds a REQ-cycle
//               counter that aborts a transfer after TIMEOUT_CYC cycles
//               without ack; without it REQ waits for ack forever.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_ctrl
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [WB_SW-1:0] cmd_sel_i,
    input  logic [WB_AW-1:0] cmd_adr_i,
    input  logic [WB_DW-1:0] cmd_dat_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WB_DW-1:0] rsp_dat_o,
    output logic             rsp_err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WB_SW-1:0] wbm_sel_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic [WB_DW-1:0] wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [WB_DW-1:0] wbm_dat_i,
    output logic             busy_o
);

    state_t           r_state,     w_state_nxt;
    logic             r_cyc,       w_cyc_nxt;
    logic             r_we,        w_we_nxt;
    logic [WB_SW-1:0] r_sel,       w_sel_nxt;
    logic [WB_AW-1:0] r_adr,       w_adr_nxt;
    logic [WB_DW-1:0] r_dat,       w_dat_nxt;
    logic             r_rsp_valid, w_rsp_valid_nxt;
    logic [WB_DW-1:0] r_rsp_dat,   w_rsp_dat_nxt;
    logic             r_rsp_err,   w_rsp_err_nxt;
    logic             r_out_en;
    logic             w_load;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic             w_timeout;
    cmd_t             w_cmd_in;
    cmd_t             w_head;

    // Ready is held low during reset and comes up on the first clock after it
    assign cmd_ready_o = r_out_en && !w_full;
    assign w_push      = cmd_valid_i && cmd_ready_o;
    assign w_cmd_in    = '{we: cmd_we_i, sel: cmd_sel_i, adr: cmd_adr_i, dat: cmd_dat_i};

    wb_cmd_fifo u_cmd_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_push  (w_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_load),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [15:0] c_timeout_lim = 16'(TIMEOUT_CYC);
    logic [15:0] r_tmo_cnt;

    // Counts REQ cycles of the current transfer; restarts on every issue
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_tmo_cnt <= 16'd0;
        end else if (w_load) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_state == ST_REQ) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    // Fires in the REQ cycle in which the count reaches the limit
    assign w_timeout = (r_state == ST_REQ) && ((r_tmo_cnt + 16'd1) == c_timeout_lim);
`else
    logic [15:0] w_unused_tmo;
    assign w_unused_tmo = 16'(TIMEOUT_CYC);
    assign w_timeout    = 1'b0;
`endif

    // Next-state and next-output logic; ack is checked before timeout
    always_comb begin
        w_state_nxt     = r_state;
        w_load          = 1'b0;
        w_cyc_nxt       = r_cyc;
        w_we_nxt        = r_we;
        w_sel_nxt       = r_sel;
        w_adr_nxt       = r_adr;
        w_dat_nxt       = r_dat;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_dat_nxt   = r_rsp_dat;
        w_rsp_err_nxt   = r_rsp_err;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wbm_ack_i) begin
                    w_cyc_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_dat_nxt   = r_we ? '0 : wbm_dat_i;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = ST_RESP;
                end else if (w_timeout) begin
                    w_cyc_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_dat_nxt   = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_rsp_valid_nxt = 1'b0;
                    if (!w_empty) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Issuing a command latches the FIFO head onto the bus
        if (w_load) begin
            w_cyc_nxt = 1'b1;
            w_we_nxt  = w_head.we;
            w_sel_nxt = w_head.sel;
            w_adr_nxt = w_head.adr;
            w_dat_nxt = w_head.we ? w_head.dat : '0;
        end
    end

    // State and registered outputs
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_out_en    <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_en    <= 1'b1;
            r_cyc       <= w_cyc_nxt;
            r_we        <= w_we_nxt;
            r_sel       <= w_sel_nxt;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_dat_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign busy_o      = (r_state != ST_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: doc/wb_master_ctrl.md
WB_MASTER_CTRL -- requirements
Module: wb_master_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: number of REQ-state cycles without ack before the transfer is aborted (range 1..65535).
REQ-002 Port wb_clk_i  in  1  the single clock; all logic is rising-edge.
REQ-003 Port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 Ports cmd_valid_i in 1, cmd_ready_o out 1: command handshake; a command transfers on the edge where both are high.
REQ-005 Ports cmd_we_i in 1, cmd_sel_i in 4, cmd_adr_i in 32, cmd_dat_i in 32: command write-enable, byte selects, address and write data.
REQ-006 Ports rsp_valid_o out 1, rsp_ready_i in 1: response handshake.
REQ-007 Ports rsp_dat_o out 32, rsp_err_o out 1: read data and timeout-error flag.
REQ-008 Ports wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_sel_o out 4; wbm_adr_o, wbm_dat_o out 32: Wishbone classic initiator outputs.
REQ-009 Ports wbm_ack_i in 1, wbm_dat_i in 32: Wishbone responder ack and read data.
REQ-010 Port busy_o  out  1  high when the FSM is not in IDLE or the command buffer is non-empty.

Function
REQ-011 Commands enter a 2-entry FIFO; cmd_ready_o is high exactly when the FIFO holds fewer than 2 entries; a push is refused when full even if a pop occurs in the same cycle.
REQ-012 FSM states: IDLE, REQ, RESP; encoding is binary and held in the shared package.
REQ-013 IDLE -> REQ when the FIFO is non-empty; the head entry is popped and registered onto wbm_adr_o/dat_o/sel_o/we_o, and wbm_cyc_o and wbm_stb_o go high on that same edge.
REQ-014 Latency: a command accepted into an empty FIFO while IDLE at edge N has cyc/stb high from edge N+1.
REQ-015 In REQ, all wbm_* outputs stay stable until wbm_ack_i is sampled high.
REQ-016 REQ -> RESP on the edge where wbm_ack_i is high; cyc/stb drop on that edge; rsp_dat_o captures wbm_dat_i for reads and 0 for writes; rsp_err_o=0; rsp_valid_o=1.
REQ-017 In RESP, rsp_valid_o, rsp_dat_o and rsp_err_o stay stable until rsp_ready_i is high; on that edge rsp_valid_o drops and the FSM goes to REQ (popping the next entry) if the FIFO is non-empty, else to IDLE.
REQ-018 Minimum transfer period with zero-wait responder and rsp_ready_i tied high: 2 cycles per command.
REQ-019 wbm_ack_i outside REQ is ignored.
REQ-020 Timeout: a 16-bit counter clears on entry to REQ and increments each REQ cycle; when it reaches TIMEOUT_CYC without ack, cyc/stb drop, the FSM goes to RESP with rsp_err_o=1 and rsp_dat_o=0.
REQ-021 Ack sampled in the same cycle the counter reaches TIMEOUT_CYC is treated as success (ack wins).
REQ-022 wbm_dat_o drives 0 for reads.

Reset
REQ-023 Asserting wb_rst_i immediately forces IDLE, empties the FIFO, clears the timeout counter and drives every output to 0, including mid-transfer cyc/stb.
REQ-024 cmd_ready_o returns high on the first edge after wb_rst_i deasserts.

Configuration
REQ-025 Macro WB_MASTER_TIMEOUT_EN: when defined, REQ-020/021 apply; when undefined, no counter is built, REQ waits indefinitely for ack and rsp_err_o is constant 0.

Structure
REQ-026 Package wb_master_pkg holds the FSM state type, WB_AW=32, WB_DW=32, WB_SW=4 and the default TIMEOUT_CYC.
REQ-027 Sub-module wb_cmd_fifo implements the 2-entry 69-bit command FIFO (we, sel, adr, dat) with push/pop/full/empty.

Verification
REQ-028 Write adr 0x3000_0000 dat 0xA5A5_0001 sel 0xF, ack after 2 cycles -> bus shows exact values, response err=0 dat=0.
REQ-029 Read adr 0x3000_0004, responder returns 0x1234_5678 with ack after 3 cycles -> rsp_dat_o=0x1234_5678, err=0.
REQ-030 Three back-to-back commands with rsp_ready_i low -> cmd_ready_o low after the third command is accepted, bus outputs unchanged during RESP hold, all three complete in order.
REQ-031 With WB_MASTER_TIMEOUT_EN, TIMEOUT_CYC=8, responder never acks -> cyc drops after 8 REQ cycles, rsp_err_o=1, rsp_dat_o=0; ack on cycle 8 -> err=0.
REQ-032 wb_rst_i pulsed during REQ -> cyc/stb/rsp_valid_o low asynchronously, FIFO empty, next command executes normally.
REQ-033 Spurious wbm_ack_i in IDLE -> no response, state unchanged.
